// File: rtl/rst_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl_if
// Description : Request/ack and reset-status bundle of the staged reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rst_seq_ctrl_if #(
    parameter int N_DOM = 4
);
    localparam int C_IDX_W = $clog2(N_DOM);

    logic               sw_rst_req;
    logic [N_DOM-1:0]   dom_ack;
    logic [N_DOM-1:0]   dom_rst;
    logic               seq_done;
    logic               seq_fault;
    logic [C_IDX_W-1:0] fault_dom;

    modport master (
        output sw_rst_req,
        output dom_ack,
        input  dom_rst,
        input  seq_done,
        input  seq_fault,
        input  fault_dom
    );

    modport slave (
        input  sw_rst_req,
        input  dom_ack,
        output dom_rst,
        output seq_done,
        output seq_fault,
        output fault_dom
    );
endinterface
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Releases reset domains one at a time, waiting on each ack.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int N_DOM       = 4,
    parameter int HOLD_CYC    = 16,
    parameter int STAGE_GAP   = 8,
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  wire logic      clk,
    input  wire logic      system_rst_n,
    rst_seq_ctrl_if.slave  bus
);
    localparam int C_IDX_W = $clog2(N_DOM);

    localparam logic [CNT_W-1:0]   C_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   C_GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0]   C_TO_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST  = C_IDX_W'(N_DOM - 1);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_WAIT_ACK = 3'd1,
        S_GAP      = 3'd2,
        S_DONE     = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [C_IDX_W-1:0] r_idx;
    logic [C_IDX_W-1:0] w_idx_nxt;
    logic [C_IDX_W-1:0] w_idx_inc;
    logic [N_DOM-1:0]   r_dom_rst;
    logic [N_DOM-1:0]   w_dom_rst_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_fault;
    logic               w_fault_nxt;
    logic [C_IDX_W-1:0] r_fault_dom;
    logic [C_IDX_W-1:0] w_fault_dom_nxt;
    logic               w_ack;

    assign w_ack     = bus.dom_ack[r_idx];
    assign w_idx_inc = r_idx + C_IDX_W'(1);

    always_ff @(posedge clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dom_rst   <= '1;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_fault_dom <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_dom_rst   <= w_dom_rst_nxt;
            r_done      <= w_done_nxt;
            r_fault     <= w_fault_nxt;
            r_fault_dom <= w_fault_dom_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + CNT_W'(1);
        w_idx_nxt       = r_idx;
        w_dom_rst_nxt   = r_dom_rst;
        w_done_nxt      = r_done;
        w_fault_nxt     = r_fault;
        w_fault_dom_nxt = r_fault_dom;

        // A software restart overrides every ack, timeout and counter event.
        if (bus.sw_rst_req) begin
            w_state_nxt     = S_HOLD;
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
            w_dom_rst_nxt   = '1;
            w_done_nxt      = 1'b0;
            w_fault_nxt     = 1'b0;
            w_fault_dom_nxt = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        w_state_nxt      = S_WAIT_ACK;
                        w_cnt_nxt        = '0;
                        w_idx_nxt        = '0;
                        w_dom_rst_nxt[0] = 1'b0;
                    end
                end
                S_WAIT_ACK: begin
                    // Ack is checked first so it wins on the final timeout cycle.
                    if (w_ack) begin
                        w_cnt_nxt = '0;
                        if (r_idx == C_IDX_LAST) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_GAP;
                        end
                    end else if (r_cnt == C_TO_LAST) begin
                        w_state_nxt     = S_FAULT;
                        w_cnt_nxt       = '0;
                        w_dom_rst_nxt   = '1;
                        w_fault_nxt     = 1'b1;
                        w_fault_dom_nxt = r_idx;
                    end
                end
                S_GAP: begin
                    if (r_cnt == C_GAP_LAST) begin
                        w_state_nxt              = S_WAIT_ACK;
                        w_cnt_nxt                = '0;
                        w_idx_nxt                = w_idx_inc;
                        w_dom_rst_nxt[w_idx_inc] = 1'b0;
                    end
                end
                S_DONE: begin
                    w_cnt_nxt = '0;
                end
                S_FAULT: begin
                    w_cnt_nxt     = '0;
                    w_dom_rst_nxt = '1;
                end
                default: begin
                    w_state_nxt   = S_HOLD;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_dom_rst_nxt = '1;
                    w_done_nxt    = 1'b0;
                    w_fault_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign bus.dom_rst   = r_dom_rst;
    assign bus.seq_done  = r_done;
    assign bus.seq_fault = r_fault;
    assign bus.fault_dom = r_fault_dom;

endmodule
`default_nettype wire
